regfile_write_arbiter: RTL and testbench

//  Shares the single RegFile write port (4-bit address, 16-bit data) among NUM_REQ requesters.

---
 rtl/regfile_write_arbiter_pkg.sv | 44 ++++
 rtl/regfile_write_arbiter_if.sv | 35 +++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 47 ++++
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rfarb_pkg
// Shared types, default widths and the round-robin pick helper used by the
// RegFile write-port arbiter.
//   rfarb_state_t : arbiter FSM state (IDLE, WRITE)
//   RFARB_ADDR_W  : default register address width
//   RFARB_DATA_W  : default register data width
//   rr_pick()     : one-hot winner among up to 8 requesters, searching from ptr
// -----------------------------------------------------------------------------
package rfarb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } rfarb_state_t;

    localparam int RFARB_ADDR_W = 4;
    localparam int RFARB_DATA_W = 16;

    // First valid requester at or after ptr, wrapping n-1 -> 0.
    // Sized for the 8-requester maximum; callers use the low n bits.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [7:0] grant;
        logic       found;
        int         idx;
        logic [2:0] idx3;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n && !found) begin
                idx  = (int'(ptr) + k) % n;
                idx3 = 3'(idx);
                if (valid[idx3]) begin
                    grant[idx3] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Requester handshake bundle plus the RegFile write-port side of the arbiter.
//   req_valid/req_addr/req_data : per-requester write requests (packed)
//   req_ready                   : one-hot accept from the arbiter
//   rf_we/rf_addr/rf_data       : RegFile write port
//   grant_id                    : requester owning the current write
//   r0_drop                     : pulse when an accepted r0 write is discarded
// Modports: master = requester/RegFile side, slave = arbiter.
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        rf_we;
    logic [ADDR_W-1:0]           rf_addr;
    logic [DATA_W-1:0]           rf_data;
    logic [$clog2(NUM_REQ)-1:0]  grant_id;
    logic                        r0_drop;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_addr, rf_data, grant_id, r0_drop
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_addr, rf_data, grant_id, r0_drop
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin picker with its rotating priority pointer.
//   i_clk, i_rst_n : clock, async active-low reset (pointer -> 0)
//   i_valid        : per-requester request
//   i_advance      : a transfer happened; move pointer past the winner
//   o_grant        : one-hot winner (zero when nothing is valid)
//   o_winner       : index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter
    import rfarb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_winner
);

    logic [ID_W-1:0] r_ptr;
    logic [7:0]      w_pick;
    logic            w_unused_pick;

    assign w_pick        = rr_pick(8'(i_valid), 3'(r_ptr), NUM_REQ);
    assign o_grant       = w_pick[NUM_REQ-1:0];
    assign w_unused_pick = &{1'b0, w_pick};

    always_comb begin
        o_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) o_winner = ID_W'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_winner == ID_W'(NUM_REQ - 1)) ? '0 : o_winner + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single RegFile write port among NUM_REQ requesters (ALU
// writeback, load return, debug poke). Round-robin accept in IDLE, then the
// registered write is held on the port for WR_CYCLES cycles.
//   i_clk       : rising-edge clock
//   i_rst_n     : async active-low reset; clears outputs, FSM and pointer
//   io_bus      : requester handshake + RegFile write port (slave modport)
//   o_grant_cnt : per-requester saturating grant counters, 16 bits each
//                 (present only when RFARB_STATS_EN is defined)
//
// state | meaning
// IDLE  | req_ready offered to the round-robin winner; waiting for a transfer
// WRITE | registered write on the port for WR_CYCLES cycles; req_ready = 0
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import rfarb_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int ADDR_W     = RFARB_ADDR_W,
    parameter  int DATA_W     = RFARB_DATA_W,
    parameter  int WR_CYCLES  = 1,
    parameter  int PROTECT_R0 = 1,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    regfile_write_arbiter_if.slave    io_bus
`ifdef RFARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     o_grant_cnt
`endif
);

    localparam logic [2:0] HOLD_INIT = 3'(WR_CYCLES - 1);

    rfarb_state_t        r_state, w_state_nxt;
    logic [2:0]          r_hold, w_hold_nxt;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_ready;
    logic [ID_W-1:0]     w_winner;
    logic                w_transfer;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_drop;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_gid;
    logic                r_r0_drop;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (io_bus.req_valid),
        .i_advance (w_transfer),
        .o_grant   (w_grant),
        .o_winner  (w_winner)
    );

    // Ready is gated by reset so it drops the moment reset asserts,
    // not at the next edge.
    assign w_ready    = (r_state == IDLE && i_rst_n) ? w_grant : '0;
    assign w_transfer = |(w_ready & io_bus.req_valid);

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = io_bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = io_bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_drop = (PROTECT_R0 != 0) && (w_sel_addr == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_state_nxt = WRITE;
                    w_hold_nxt  = HOLD_INIT;
                end
            end
            WRITE: begin
                if (r_hold == '0) w_state_nxt = IDLE;
                else              w_hold_nxt  = r_hold - 3'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A dropped r0 write still walks through WRITE so timing is identical;
    // only the enable is suppressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_gid     <= '0;
            r_r0_drop <= 1'b0;
        end else begin
            r_r0_drop <= 1'b0;
            if (w_transfer) begin
                r_we      <= !w_drop;
                r_addr    <= w_sel_addr;
                r_data    <= w_sel_data;
                r_gid     <= w_winner;
                r_r0_drop <= w_drop;
            end else if (r_state == WRITE && r_hold == '0) begin
                r_we <= 1'b0;
            end
        end
    end

    assign io_bus.req_ready = w_ready;
    assign io_bus.rf_we     = r_we;
    assign io_bus.rf_addr   = r_addr;
    assign io_bus.rf_data   = r_data;
    assign io_bus.grant_id  = r_gid;
    assign io_bus.r0_drop   = r_r0_drop;

`ifdef RFARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_grant_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant_cnt <= '0;
        end else if (w_transfer) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && r_grant_cnt[i] != 16'hFFFF)
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter. Three instances share clock and
// reset: dut_a (defaults), dut_b (WR_CYCLES=3), dut_c (PROTECT_R0=0).
// Grant counter checks are compiled when RFARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(16)) bus_a ();
    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(16)) bus_b ();
    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(16)) bus_c ();

`ifdef RFARB_STATS_EN
    logic [47:0] cnt_a, cnt_b, cnt_c;
`endif

    regfile_write_arbiter #(.NUM_REQ(3), .WR_CYCLES(1), .PROTECT_R0(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_a)
`ifdef RFARB_STATS_EN
        , .o_grant_cnt(cnt_a)
`endif
    );

    regfile_write_arbiter #(.NUM_REQ(3), .WR_CYCLES(3), .PROTECT_R0(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_b)
`ifdef RFARB_STATS_EN
        , .o_grant_cnt(cnt_b)
`endif
    );

    regfile_write_arbiter #(.NUM_REQ(3), .WR_CYCLES(1), .PROTECT_R0(0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_c)
`ifdef RFARB_STATS_EN
        , .o_grant_cnt(cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus_a.req_valid = '0; bus_a.req_addr = '0; bus_a.req_data = '0;
        bus_b.req_valid = '0; bus_b.req_addr = '0; bus_b.req_data = '0;
        bus_c.req_valid = '0; bus_c.req_addr = '0; bus_c.req_data = '0;
        tick();
        tick();

        // reset state; ready must stay low even with requests pending
        bus_a.req_valid = 3'b111;
        #1;
        check_eq("rst_we",    32'(bus_a.rf_we),     32'd0);
        check_eq("rst_addr",  32'(bus_a.rf_addr),   32'd0);
        check_eq("rst_data",  32'(bus_a.rf_data),   32'd0);
        check_eq("rst_gid",   32'(bus_a.grant_id),  32'd0);
        check_eq("rst_drop",  32'(bus_a.r0_drop),   32'd0);
        check_eq("rst_ready", 32'(bus_a.req_ready), 32'd0);
        bus_a.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // single write from req1
        bus_a.req_addr  = {4'h3, 4'hD, 4'h5};
        bus_a.req_data  = {16'h3333, 16'hFFFA, 16'h5555};
        bus_a.req_valid = 3'b010;
        #1;
        check_eq("t2_ready", 32'(bus_a.req_ready), 32'h2);
        tick();
        bus_a.req_valid = '0;
        check_eq("t2_we",       32'(bus_a.rf_we),     32'd1);
        check_eq("t2_addr",     32'(bus_a.rf_addr),   32'hD);
        check_eq("t2_data",     32'(bus_a.rf_data),   32'hFFFA);
        check_eq("t2_gid",      32'(bus_a.grant_id),  32'd1);
        check_eq("t2_ready_wr", 32'(bus_a.req_ready), 32'd0);
        tick();
        check_eq("t2_we_off",   32'(bus_a.rf_we),     32'd0);

        // reset mid-WRITE; pointer is 2 here, so req0 winning afterwards
        // shows the pointer was cleared
        bus_a.req_valid = 3'b010;
        #1;
        check_eq("t1_ready", 32'(bus_a.req_ready), 32'h2);
        tick();
        check_eq("t1_we_pre", 32'(bus_a.rf_we), 32'd1);
        bus_a.req_valid = 3'b101;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_we_async",   32'(bus_a.rf_we),     32'd0);
        check_eq("t1_addr_async", 32'(bus_a.rf_addr),   32'd0);
        check_eq("t1_data_async", 32'(bus_a.rf_data),   32'd0);
        check_eq("t1_gid_async",  32'(bus_a.grant_id),  32'd0);
        check_eq("t1_rdy_async",  32'(bus_a.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("t1_first_req0", 32'(bus_a.req_ready), 32'h1);
        tick();
        bus_a.req_valid = '0;
        check_eq("t1_we_post",   32'(bus_a.rf_we),   32'd1);
        check_eq("t1_gid_post",  32'(bus_a.grant_id), 32'd0);
        check_eq("t1_addr_post", 32'(bus_a.rf_addr), 32'h5);
        tick();

        // all three valid: order 0,1,2,0,1,2, one write every 2nd cycle
        do_reset();
        bus_a.req_valid = 3'b111;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 2 == 0) begin
                check_eq($sformatf("t3_ready_%0d", k), 32'(bus_a.req_ready),
                         32'(1 << ((k / 2) % 3)));
                check_eq($sformatf("t3_we_%0d", k), 32'(bus_a.rf_we), 32'd0);
            end else begin
                check_eq($sformatf("t3_ready_%0d", k), 32'(bus_a.req_ready), 32'd0);
                check_eq($sformatf("t3_we_%0d", k), 32'(bus_a.rf_we), 32'd1);
                check_eq($sformatf("t3_gid_%0d", k), 32'(bus_a.grant_id),
                         32'(((k - 1) / 2) % 3));
            end
            tick();
        end
        bus_a.req_valid = '0;
        tick();
        tick();

        // WR_CYCLES=3: held write, req0 waits until IDLE
        bus_b.req_addr  = {4'hA, 4'h0, 4'h7};
        bus_b.req_data  = {16'hBEEF, 16'h0000, 16'h0707};
        bus_b.req_valid = 3'b100;
        #1;
        check_eq("t4_ready2", 32'(bus_b.req_ready), 32'h4);
        tick();
        bus_b.req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("t4_we_%0d", k),    32'(bus_b.rf_we),     32'd1);
            check_eq($sformatf("t4_addr_%0d", k),  32'(bus_b.rf_addr),   32'hA);
            check_eq($sformatf("t4_data_%0d", k),  32'(bus_b.rf_data),   32'hBEEF);
            check_eq($sformatf("t4_ready_%0d", k), 32'(bus_b.req_ready), 32'd0);
            tick();
        end
        check_eq("t4_we_idle",  32'(bus_b.rf_we),     32'd0);
        check_eq("t4_ready0",   32'(bus_b.req_ready), 32'h1);
        tick();
        bus_b.req_valid = '0;
        check_eq("t4_we_req0",   32'(bus_b.rf_we),    32'd1);
        check_eq("t4_addr_req0", 32'(bus_b.rf_addr),  32'h7);
        check_eq("t4_gid_req0",  32'(bus_b.grant_id), 32'd0);
        tick();

        // r0 write: dropped on dut_a, performed on dut_c
        bus_a.req_addr  = {4'h3, 4'hD, 4'h0};
        bus_a.req_data  = {16'h3333, 16'hFFFA, 16'h1234};
        bus_a.req_valid = 3'b001;
        bus_c.req_addr  = {4'h3, 4'hD, 4'h0};
        bus_c.req_data  = {16'h3333, 16'hFFFA, 16'h1234};
        bus_c.req_valid = 3'b001;
        #1;
        check_eq("t5_ready_a", 32'(bus_a.req_ready), 32'h1);
        check_eq("t5_ready_c", 32'(bus_c.req_ready), 32'h1);
        tick();
        bus_a.req_valid = '0;
        bus_c.req_valid = '0;
        check_eq("t5_drop_a",   32'(bus_a.r0_drop), 32'd1);
        check_eq("t5_we_a",     32'(bus_a.rf_we),   32'd0);
        check_eq("t5_we_c",     32'(bus_c.rf_we),   32'd1);
        check_eq("t5_addr_c",   32'(bus_c.rf_addr), 32'h0);
        check_eq("t5_data_c",   32'(bus_c.rf_data), 32'h1234);
        check_eq("t5_drop_c",   32'(bus_c.r0_drop), 32'd0);
        check_eq("t5_rdy_a_wr", 32'(bus_a.req_ready), 32'd0);
        tick();
        check_eq("t5_drop_a_end", 32'(bus_a.r0_drop), 32'd0);
        check_eq("t5_we_a_end",   32'(bus_a.rf_we),   32'd0);
        check_eq("t5_we_c_end",   32'(bus_c.rf_we),   32'd0);

`ifdef RFARB_STATS_EN
        // five grants to req1, then saturation at FFFF
        do_reset();
        bus_a.req_addr  = {4'h3, 4'hD, 4'h5};
        bus_a.req_valid = 3'b010;
        for (int k = 0; k < 10; k++) tick();
        bus_a.req_valid = '0;
        tick();
        check_eq("t6_cnt1", 32'(cnt_a[31:16]), 32'd5);
        check_eq("t6_cnt0", 32'(cnt_a[15:0]),  32'd0);
        dut_a.r_grant_cnt[1] = 16'hFFFF;
        #1;
        bus_a.req_valid = 3'b010;
        tick();
        bus_a.req_valid = '0;
        tick();
        check_eq("t6_sat", 32'(cnt_a[31:16]), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
